// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the uart receive path:
//   - rdr bit-field positions (data byte, parity error, framing error)
//   - default FIFO depth and character-timeout length in bit-times
//   - ENTRY_W, the stored width of one FIFO entry
// Optional feature macro: UART_RX_FIFO_ERR_FLAG_EN
//   defined   -> entries carry {fe, pe, data} (10 bits)
//   undefined -> entries carry data only (8 bits)
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_LSB = 0;
  localparam int PE_BIT   = 8;
  localparam int FE_BIT   = 9;

  localparam int DEPTH_DEFAULT        = 16;
  localparam int TIMEOUT_BITS_DEFAULT = 40;

`ifdef UART_RX_FIFO_ERR_FLAG_EN
  localparam int ENTRY_W = 10;
`else
  localparam int ENTRY_W = 8;
`endif

endpackage

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// DEPTH x W register array: one synchronous write port, one asynchronous
// read port, so the FIFO head is visible without a read cycle.
// Ports:
//   clk    in   system clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  data at raddr (combinational)
// ---------------------------------------------------------------------------
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = 4,
  parameter int W     = ENTRY_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Storage carries no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side character buffer between the uart receiver core and the
// register file. The oldest character is presented first-word-fall-through
// on rdr; the block also raises a level-threshold interrupt, a sticky
// character-timeout interrupt and a sticky overrun flag.
// Optional feature macro: UART_RX_FIFO_ERR_FLAG_EN (store fe/pe per entry
// and show them on rdr[9:8]; otherwise rdr[9:8] read 0).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rx_valid/rx_data  character strobe and byte from the receiver
//   rx_fe/rx_pe       framing / parity error of that character
//   bit_tick          one pulse per bit-time
//   rx_read           rdr was read: pop
//   sr_read           status was read: clear overrun
//   flush             discard all contents
//   trig_lvl          threshold level, 0 disables thr_int
//   rdr               {22'b0, fe, pe, data}, 0 when empty
//   level/empty/full  occupancy
//   overrun           sticky dropped-character flag
//   thr_int           level >= trig_lvl (trig_lvl != 0)
//   to_int            sticky character-timeout interrupt
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEFAULT,
  parameter int AW           = 4,
  parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_fe,
  input  logic        rx_pe,
  input  logic        bit_tick,
  input  logic        rx_read,
  input  logic        sr_read,
  input  logic        flush,
  input  logic [AW:0] trig_lvl,
  output logic [31:0] rdr,
  output logic [AW:0] level,
  output logic        empty,
  output logic        full,
  output logic        overrun,
  output logic        thr_int,
  output logic        to_int
);

  localparam int            CW       = $clog2(TIMEOUT_BITS + 1);
  localparam logic [AW:0]   DEPTH_L  = DEPTH[AW:0];
  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [CW-1:0] TO_MAX   = CW'(TIMEOUT_BITS);
  localparam logic [CW-1:0] CNT_ONE  = 1;

  logic [AW:0]         r_wrPtr;
  logic [AW:0]         r_rdPtr;
  logic [CW-1:0]       r_toCnt;
  logic [CW-1:0]       w_toCntNext;
  logic [AW:0]         w_level;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [ENTRY_W-1:0]  w_wrEntry;
  logic [ENTRY_W-1:0]  w_head;

  // Extra pointer MSB separates full from empty; subtraction wraps naturally.
  assign w_level = r_wrPtr - r_rdPtr;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == DEPTH_L);

  // A pop while full frees the slot the concurrent push needs.
  assign w_pop  = rx_read && !w_empty;
  assign w_push = rx_valid && (!w_full || w_pop);
  assign w_drop = rx_valid && w_full && !w_pop && !flush;

`ifdef UART_RX_FIFO_ERR_FLAG_EN
  assign w_wrEntry = {rx_fe, rx_pe, rx_data};
`else
  assign w_wrEntry = rx_data;
  logic w_unusedErr;
  assign w_unusedErr = rx_fe ^ rx_pe;
`endif

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_push && !flush),
    .waddr (r_wrPtr[AW-1:0]),
    .wdata (w_wrEntry),
    .raddr (r_rdPtr[AW-1:0]),
    .rdata (w_head)
  );

  // Pointer update; flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
    end
  end

  // Sticky overrun; a new drop beats a coincident status read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (w_drop) begin
      overrun <= 1'b1;
    end else if (sr_read) begin
      overrun <= 1'b0;
    end
  end

  // Idle counter: restarts on any FIFO activity, saturates at the timeout.
  always_comb begin
    w_toCntNext = r_toCnt;
    if (flush || w_push || w_pop || w_empty) begin
      w_toCntNext = '0;
    end else if (bit_tick && (r_toCnt != TO_MAX)) begin
      w_toCntNext = r_toCnt + CNT_ONE;
    end
  end

  // to_int rises on the same edge the counter reaches the limit, so the
  // interrupt is visible right after the final bit_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_toCnt <= '0;
      to_int  <= 1'b0;
    end else begin
      r_toCnt <= w_toCntNext;
      if (flush || w_pop || w_empty) begin
        to_int <= 1'b0;
      end else if (w_toCntNext == TO_MAX) begin
        to_int <= 1'b1;
      end
    end
  end

  // rdr is built from the head entry and forced to zero when empty.
  always_comb begin
    rdr = '0;
    if (!w_empty) begin
      rdr[DATA_LSB +: 8] = w_head[7:0];
`ifdef UART_RX_FIFO_ERR_FLAG_EN
      rdr[FE_BIT] = w_head[9];
      rdr[PE_BIT] = w_head[8];
`endif
    end
  end

  assign level   = w_level;
  assign empty   = w_empty;
  assign full    = w_full;
  assign thr_int = (trig_lvl != '0) && (w_level >= trig_lvl);

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between a uart receiver core and the register file.
- Stores received characters with their per-character error flags.
- Presents the oldest character as a 32-bit rdr word, first-word-fall-through.
- Generates a level-threshold interrupt, a character-timeout interrupt and a sticky overrun flag for the status register.

Parameters:
- DEPTH, 16: number of entries; must be a power of two.
- AW, 4: pointer width, log2(DEPTH).
- TIMEOUT_BITS, 40: bit-times of idle (4 characters at 10 bits each) before the timeout interrupt fires.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle pulse from the receiver: a character is complete
- rx_data  in  8  received character, valid with rx_valid
- rx_fe  in  1  framing error for this character
- rx_pe  in  1  parity error for this character
- bit_tick  in  1  one-cycle pulse once per bit-time (baud/1)
- rx_read  in  1  one-cycle pulse from regs: rdr was read, so pop
- sr_read  in  1  one-cycle pulse from regs: status was read, so clear overrun
- flush  in  1  one-cycle pulse: discard all contents
- trig_lvl  in  AW+1  interrupt threshold; 0 disables the threshold interrupt
- rdr  out  32  head entry: {22'b0, fe, pe, data[7:0]}; 32'h0 when empty
- level  out  AW+1  current occupancy, 0..DEPTH
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- overrun  out  1  sticky: a character was dropped
- thr_int  out  1  level >= trig_lvl and trig_lvl != 0
- to_int  out  1  sticky character-timeout interrupt

Behaviour:
- Reset (async, on rst high):
  - pointers = 0, level = 0, so empty = 1 and full = 0.
  - overrun = 0, to_int = 0, timeout counter = 0, rdr = 0.
- Storage and read path:
  - Circular buffer of DEPTH entries, 10 bits each.
  - Write and read pointers are AW+1 bits; the extra MSB distinguishes full from empty, and wrap-around is natural modulo 2^(AW+1).
  - rdr is combinational from the head entry (zero latency).
  - A pushed character is visible on rdr the cycle after rx_valid.
- Push: on rx_valid with !full, write the entry and increment wr_ptr.
- Pop: on rx_read with !empty, increment rd_ptr. rx_read while empty is ignored, with no underflow.
- Simultaneous push and pop:
  - Both take effect and level is unchanged.
  - If full, the pop frees a slot in the same cycle, so the push is accepted and overrun is NOT set.
- Overrun:
  - rx_valid while full with no concurrent pop: the character is dropped and overrun is set.
  - overrun clears on sr_read. If sr_read and a new overrun event coincide, set wins.
- Flush:
  - Pointers and level go to 0, to_int clears, overrun is unaffected.
  - Flush has priority over push/pop in the same cycle; the concurrent character is dropped and overrun is not set.
- thr_int: combinational from level and trig_lvl.
- Timeout counter (width sufficient for TIMEOUT_BITS):
  - Clears on any accepted push, any pop, flush, or while empty.
  - Otherwise it increments on bit_tick and saturates at TIMEOUT_BITS.
  - When it reaches TIMEOUT_BITS, to_int sets.
  - to_int clears on pop, flush, or when empty.
- There is no state machine beyond pointers and counter; all state updates are on the rising edge of clk.

Optional Feature:
- Macro: UART_RX_FIFO_ERR_FLAG_EN.
- Defined: entries are 10 bits; rdr[9:8] = {fe, pe} of the head character.
- Undefined:
  - Entries are 8 bits and rx_fe/rx_pe are ignored.
  - rdr[9:8] always read 0.
  - Storage shrinks accordingly; all other behaviour is identical.

Decomposition:
- A shared package (uart_pkg) holds:
  - the rdr bit-field positions (DATA_LSB=0, PE_BIT=8, FE_BIT=9);
  - the default DEPTH and TIMEOUT_BITS constants.
- One natural sub-module, uart_fifo_mem: a DEPTH x width register array with a synchronous write port and an asynchronous read port. Pointer/flag logic stays in the top of this block.

Test Plan:
- Push 0x41, 0x42, 0x43 → rdr = 0x00000041, level = 3. Pop → rdr = 0x00000042. Pop twice → empty = 1, rdr = 0.
- Push 16 chars 0x00..0x0F, then rx_valid with 0x55 → full = 1, overrun = 1, 0x55 absent. Drain all → order 0x00..0x0F. sr_read → overrun = 0.
- With full, assert rx_valid(0x77) and rx_read in the same cycle → level stays 16, overrun = 0, last entry = 0x77.
- trig_lvl = 4: push 3 → thr_int = 0; push 4th → thr_int = 1; pop → thr_int = 0. Set trig_lvl = 0 → thr_int = 0 at any level.
- Push 1 char, then 39 bit_ticks → to_int = 0; 40th tick → to_int = 1; pop → to_int = 0. Repeat with a push at tick 20 → timeout restarts and to_int fires 40 ticks after that push.
- With ERR_FLAG_EN, push 0x5A with rx_fe = 1, rx_pe = 0 → rdr = 0x0000025A. Then assert rst mid-stream → all outputs at reset values immediately, before the next clk edge.
